// File: rtl/psum_drain_scheduler.sv
// Partial-sum drain scheduler: reads the per-unit psum FIFOs after each tile, accumulates
// TILE_NUM tiles into a UNIT_NUM x UNIT_NUM bank, then streams the finished block out.
module psum_drain_scheduler #(
   parameter int unsigned UNIT_NUM   = 8,
   parameter int unsigned PSUM_WIDTH = 20,
   parameter int unsigned ACC_WIDTH  = 24,
   parameter int unsigned TILE_NUM   = 24
) (
   input  logic                         s_clk,
   input  logic                         s_rst_n,
   input  logic                         i_finish_calc,
   output logic [UNIT_NUM-1:0]          o_psum_grant,
   output logic                         o_psum_rd,
   input  logic signed [PSUM_WIDTH-1:0] i_psum_data,
   output logic                         o_tile_release,
   output logic                         o_out_valid,
   output logic [ACC_WIDTH-1:0]         o_out_data,
   output logic                         o_out_last,
   input  logic                         i_out_ready,
   output logic                         o_busy,
   output logic                         o_overrun
);

   localparam int unsigned N      = UNIT_NUM * UNIT_NUM;
   localparam int unsigned IDX_W  = $clog2(N);
   localparam int unsigned TILE_W = (TILE_NUM > 1) ? $clog2(TILE_NUM) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;

   logic [1:0]                  state, state_d;
   logic [IDX_W-1:0]            rd_idx, wr_idx, out_idx;
   logic                        dv;
   logic [TILE_W-1:0]           tile_cnt;
   logic signed [ACC_WIDTH-1:0] acc [N];

   logic                        start_c, last_tile_c, drain_done_c, out_hs_c, flush_done_c;
   logic [IDX_W-1:0]            next_idx_c;
   logic signed [ACC_WIDTH-1:0] base_c, sat_c;
   logic signed [ACC_WIDTH:0]   sum_c;

   // Next-state and control strobes
   always_comb begin
      state_d      = state;
      start_c      = 1'b0;
      last_tile_c  = (tile_cnt == TILE_W'(TILE_NUM - 1));
      drain_done_c = dv && (wr_idx == IDX_W'(N - 1));
      out_hs_c     = o_out_valid && i_out_ready;
      flush_done_c = out_hs_c && o_out_last;
      next_idx_c   = out_idx + IDX_W'(1);
      case (state)
         S_IDLE, S_WAIT: begin
            if (i_finish_calc) begin
               state_d = S_DRAIN;
               start_c = 1'b1;
            end
         end
         S_DRAIN: if (drain_done_c) state_d = last_tile_c ? S_FLUSH : S_WAIT;
         S_FLUSH: if (flush_done_c) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Saturating accumulate; the first tile of a block overwrites stale bank contents
   always_comb begin
      base_c = (tile_cnt == '0) ? '0 : acc[wr_idx];
      sum_c  = (ACC_WIDTH+1)'(base_c) + (ACC_WIDTH+1)'(i_psum_data);
      if (sum_c[ACC_WIDTH] != sum_c[ACC_WIDTH-1])
         sat_c = sum_c[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      else
         sat_c = sum_c[ACC_WIDTH-1:0];
   end

   always_ff @(posedge s_clk) begin
      if (dv) acc[wr_idx] <= sat_c;
   end

   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state          <= S_IDLE;
         rd_idx         <= '0;
         wr_idx         <= '0;
         out_idx        <= '0;
         dv             <= 1'b0;
         tile_cnt       <= '0;
         o_psum_grant   <= '0;
         o_psum_rd      <= 1'b0;
         o_tile_release <= 1'b0;
         o_out_valid    <= 1'b0;
         o_out_data     <= '0;
         o_out_last     <= 1'b0;
         o_busy         <= 1'b0;
         o_overrun      <= 1'b0;
      end else begin
         state          <= state_d;
         o_busy         <= (state_d != S_IDLE);
         dv             <= o_psum_rd;
         wr_idx         <= rd_idx;
         o_tile_release <= (drain_done_c && !last_tile_c) || flush_done_c;

         if (i_finish_calc && ((state == S_DRAIN) || (state == S_FLUSH)))
            o_overrun <= 1'b1;

         // Read sequencer: N back-to-back reads with a rotating one-hot grant
         if (start_c) begin
            o_psum_rd    <= 1'b1;
            o_psum_grant <= UNIT_NUM'(1);
            rd_idx       <= '0;
         end else if (o_psum_rd) begin
            if (rd_idx == IDX_W'(N - 1)) begin
               o_psum_rd    <= 1'b0;
               o_psum_grant <= '0;
            end else begin
               rd_idx       <= rd_idx + IDX_W'(1);
               o_psum_grant <= {o_psum_grant[UNIT_NUM-2:0], o_psum_grant[UNIT_NUM-1]};
            end
         end

         if (drain_done_c && !last_tile_c) tile_cnt <= tile_cnt + TILE_W'(1);
         if (flush_done_c) tile_cnt <= '0;

         // Output streamer: words only advance on a handshake
         if (drain_done_c && last_tile_c) begin
            o_out_valid <= 1'b1;
            out_idx     <= '0;
            o_out_data  <= acc[0];
            o_out_last  <= 1'b0;
         end else if (out_hs_c) begin
            if (o_out_last) begin
               o_out_valid <= 1'b0;
               o_out_last  <= 1'b0;
            end else begin
               out_idx    <= next_idx_c;
               o_out_data <= acc[next_idx_c];
               o_out_last <= (next_idx_c == IDX_W'(N - 1));
            end
         end
      end
   end

endmodule

// File: tb/tb_psum_drain_scheduler.sv
// Bench for psum_drain_scheduler: random psum data and output backpressure, checked
// against a per-entry saturating accumulator model.
module tb_psum_drain_scheduler;

   localparam int UNIT_NUM   = 8;
   localparam int PSUM_WIDTH = 20;
   localparam int ACC_WIDTH  = 24;
   localparam int TILE_NUM   = 24;
   localparam int N          = UNIT_NUM * UNIT_NUM;
   localparam int LOG_LEN    = N + 4;
   localparam longint MAXV   = 64'sd8388607;
   localparam longint MINV   = -64'sd8388608;

   localparam int MODE_ONE = 0, MODE_MAX = 1, MODE_MIN = 2, MODE_IDX = 3, MODE_RAND = 4;

   logic                         s_clk;
   logic                         s_rst_n;
   logic                         i_finish_calc;
   logic [UNIT_NUM-1:0]          o_psum_grant;
   logic                         o_psum_rd;
   logic signed [PSUM_WIDTH-1:0] i_psum_data;
   logic                         o_tile_release;
   logic                         o_out_valid;
   logic [ACC_WIDTH-1:0]         o_out_data;
   logic                         o_out_last;
   logic                         i_out_ready;
   logic                         o_busy;
   logic                         o_overrun;

   psum_drain_scheduler #(
      .UNIT_NUM(UNIT_NUM), .PSUM_WIDTH(PSUM_WIDTH), .ACC_WIDTH(ACC_WIDTH), .TILE_NUM(TILE_NUM)
   ) dut (
      .s_clk(s_clk), .s_rst_n(s_rst_n), .i_finish_calc(i_finish_calc),
      .o_psum_grant(o_psum_grant), .o_psum_rd(o_psum_rd), .i_psum_data(i_psum_data),
      .o_tile_release(o_tile_release), .o_out_valid(o_out_valid), .o_out_data(o_out_data),
      .o_out_last(o_out_last), .i_out_ready(i_out_ready), .o_busy(o_busy), .o_overrun(o_overrun)
   );

   initial s_clk = 1'b0;
   always #5 s_clk = ~s_clk;

   int checks = 0;
   int errors = 0;

   longint              exp_acc [N];
   logic                rd_log  [LOG_LEN];
   logic [UNIT_NUM-1:0] gr_log  [LOG_LEN];
   logic                rel_log [LOG_LEN];
   logic                vld_log [LOG_LEN];
   int                  n_rd;
   int                  n_rel_total;
   logic                final_vld;
   logic [ACC_WIDTH-1:0] got_q[$];
   logic                last_q[$];
   int                  hs, stall_bad;
   bit                  timeout;
   logic                post_valid, post_rel, post_busy;

   function automatic longint sat_acc(input longint v);
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
   endfunction

   function automatic longint psum_val(input int mode, input int r);
      case (mode)
         MODE_ONE: return 1;
         MODE_MAX: return 524287;
         MODE_MIN: return -524288;
         MODE_IDX: return longint'(r);
         default:  return longint'($urandom_range(0, 1048575)) - 524288;
      endcase
   endfunction

   task automatic do_reset();
      s_rst_n       = 1'b0;
      i_finish_calc = 1'b0;
      i_out_ready   = 1'b0;
      i_psum_data   = '0;
      repeat (3) @(negedge s_clk);
      s_rst_n = 1'b1;
      @(negedge s_clk);
   endtask

   // One tile: pulse finish, serve psum words one cycle after each read, log outputs per cycle.
   task automatic run_drain(input int tile, input int mode, input int ovr_at);
      int r;
      longint v, base;
      r    = 0;
      n_rd = 0;
      @(negedge s_clk);
      i_finish_calc = 1'b1;
      @(negedge s_clk);
      i_finish_calc = 1'b0;
      rd_log[0] = 1'b0; gr_log[0] = '0; rel_log[0] = 1'b0; vld_log[0] = 1'b0;
      for (int k = 1; k < LOG_LEN; k++) begin
         if (k > 1) @(negedge s_clk);
         i_finish_calc = (k == ovr_at);
         rd_log[k]  = o_psum_rd;
         gr_log[k]  = o_psum_grant;
         rel_log[k] = o_tile_release;
         vld_log[k] = o_out_valid;
         if (o_psum_rd === 1'b1) n_rd++;
         if (rd_log[k-1] === 1'b1 && r < N) begin
            v           = psum_val(mode, r);
            i_psum_data = PSUM_WIDTH'(v);
            base        = (tile == 0) ? 0 : exp_acc[r];
            exp_acc[r]  = sat_acc(base + v);
            r++;
         end else begin
            i_psum_data = PSUM_WIDTH'($urandom);
         end
      end
      i_finish_calc = 1'b0;
   endtask

   task automatic run_block(input int mode);
      n_rel_total = 0;
      final_vld   = 1'b0;
      for (int tl = 0; tl < TILE_NUM; tl++) begin
         run_drain(tl, mode, -1);
         for (int k = 0; k < LOG_LEN; k++) if (rel_log[k] === 1'b1) n_rel_total++;
         if (tl == TILE_NUM - 1) final_vld = vld_log[N+2];
      end
   endtask

   // Consume up to stop_after words; records stability violations while stalled.
   task automatic run_flush(input bit rand_ready, input int stop_after);
      logic                 prev_stall, prev_last;
      logic [ACC_WIDTH-1:0] prev_data;
      hs = 0; stall_bad = 0; timeout = 1'b0;
      prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
      got_q.delete(); last_q.delete();
      for (int c = 0; c < 4000 && hs < stop_after; c++) begin
         @(negedge s_clk);
         if (prev_stall && (o_out_valid !== 1'b1 || o_out_data !== prev_data || o_out_last !== prev_last))
            stall_bad++;
         i_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (o_out_valid === 1'b1 && i_out_ready) begin
            got_q.push_back(o_out_data);
            last_q.push_back(o_out_last);
            hs++;
         end
         prev_stall = (o_out_valid === 1'b1) && !i_out_ready;
         prev_data  = o_out_data;
         prev_last  = o_out_last;
      end
      if (hs < stop_after) timeout = 1'b1;
      if (stop_after == N) begin
         @(negedge s_clk);
         i_out_ready = 1'b0;
         post_valid  = o_out_valid;
         post_rel    = o_tile_release;
         post_busy   = o_busy;
      end
   endtask

   task automatic test_reset();
      s_rst_n = 1'b0;
      i_finish_calc = 1'b0; i_out_ready = 1'b0; i_psum_data = '0;
      repeat (2) @(negedge s_clk);
      checks++;
      if ({o_psum_grant, o_psum_rd, o_tile_release, o_out_valid, o_out_data, o_out_last, o_busy, o_overrun} !== '0) begin
         errors++;
         $display("FAIL reset_outputs grant=%h rd=%b rel=%b vld=%b data=%h last=%b busy=%b ovr=%b expected all 0",
                  o_psum_grant, o_psum_rd, o_tile_release, o_out_valid, o_out_data, o_out_last, o_busy, o_overrun);
      end
      s_rst_n = 1'b1;
      repeat (3) @(negedge s_clk);
      checks++;
      if ({o_busy, o_psum_rd, o_out_valid} !== 3'b000) begin
         errors++;
         $display("FAIL idle_after_reset busy=%b rd=%b vld=%b expected 0 0 0", o_busy, o_psum_rd, o_out_valid);
      end
   endtask

   task automatic test_grant_sequence();
      logic [UNIT_NUM-1:0] eg;
      do_reset();
      run_drain(0, MODE_RAND, -1);
      for (int k = 1; k <= N + 1; k++) begin
         eg = (k <= N) ? UNIT_NUM'(1 << ((k - 1) % UNIT_NUM)) : '0;
         checks++;
         if ({rd_log[k], gr_log[k]} !== {(k <= N), eg}) begin
            errors++;
            $display("FAIL grant_seq t+%0d rd=%b grant=%h expected rd=%b grant=%h", k, rd_log[k], gr_log[k], (k <= N), eg);
         end
      end
      checks++;
      if (n_rd != N) begin errors++; $display("FAIL drain_read_count got %0d expected %0d", n_rd, N); end
      checks++;
      if (rel_log[N+2] !== 1'b1 || rel_log[N+1] !== 1'b0) begin
         errors++;
         $display("FAIL release_timing t+%0d=%b t+%0d=%b expected 0 1", N+1, rel_log[N+1], N+2, rel_log[N+2]);
      end
   endtask

   // Continues the block started by test_grant_sequence (tile 1 onward).
   task automatic test_overrun();
      run_drain(1, MODE_RAND, 10);
      checks++;
      if (o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b expected 1", o_overrun); end
      checks++;
      if (n_rd != N) begin errors++; $display("FAIL overrun_read_count got %0d expected %0d", n_rd, N); end
      checks++;
      if (rel_log[N+2] !== 1'b1) begin errors++; $display("FAIL overrun_release got %b expected 1", rel_log[N+2]); end
      for (int tl = 2; tl < TILE_NUM; tl++) begin
         run_drain(tl, MODE_RAND, -1);
         if (tl >= TILE_NUM - 2) begin
            checks++;
            if ({rel_log[N+2], vld_log[N+2]} !== ((tl == TILE_NUM - 1) ? 2'b01 : 2'b10)) begin
               errors++;
               $display("FAIL tile_count tile=%0d rel=%b vld=%b expected %s", tl, rel_log[N+2], vld_log[N+2],
                        (tl == TILE_NUM - 1) ? "rel=0 vld=1" : "rel=1 vld=0");
            end
         end
      end
      run_flush(1'b0, N);
      for (int i = 0; i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== ACC_WIDTH'(exp_acc[i])) begin
            errors++;
            $display("FAIL random_data word=%0d got %h expected %h", i, got_q[i], ACC_WIDTH'(exp_acc[i]));
         end
      end
      checks++;
      if (hs != N || o_overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_block_end handshakes=%0d overrun=%b expected %0d 1", hs, o_overrun, N);
      end
   endtask

   task automatic test_single_block();
      do_reset();
      run_block(MODE_ONE);
      checks++;
      if (n_rel_total != TILE_NUM - 1 || final_vld !== 1'b1) begin
         errors++;
         $display("FAIL single_releases got %0d vld=%b expected %0d vld=1", n_rel_total, final_vld, TILE_NUM - 1);
      end
      run_flush(1'b0, N);
      for (int i = 0; i < got_q.size(); i++) begin
         checks++;
         if ({got_q[i], last_q[i]} !== {ACC_WIDTH'(TILE_NUM), (i == N - 1)}) begin
            errors++;
            $display("FAIL single_word word=%0d got %0d last=%b expected %0d last=%b", i, got_q[i], last_q[i], TILE_NUM, (i == N - 1));
         end
      end
      checks++;
      if ({timeout, post_valid, post_rel, post_busy} !== 4'b0010) begin
         errors++;
         $display("FAIL single_end timeout=%b vld=%b rel=%b busy=%b expected 0 0 1 0", timeout, post_valid, post_rel, post_busy);
      end
   endtask

   task automatic test_saturation();
      run_block(MODE_MAX);
      run_flush(1'b0, N);
      checks++;
      if (got_q.size() != N) begin errors++; $display("FAIL sat_pos_count got %0d expected %0d", got_q.size(), N); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== 24'h7FFFFF) begin errors++; $display("FAIL sat_pos word=%0d got %h expected 7fffff", i, got_q[i]); end
      end
      run_block(MODE_MIN);
      run_flush(1'b0, N);
      checks++;
      if (got_q.size() != N) begin errors++; $display("FAIL sat_neg_count got %0d expected %0d", got_q.size(), N); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== 24'h800000) begin errors++; $display("FAIL sat_neg word=%0d got %h expected 800000", i, got_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      run_block(MODE_RAND);
      run_flush(1'b1, N);
      checks++;
      if (timeout || hs != N || stall_bad != 0 || post_valid !== 1'b0) begin
         errors++;
         $display("FAIL backpressure timeout=%b handshakes=%0d stall_changes=%0d post_vld=%b expected 0 %0d 0 0",
                  timeout, hs, stall_bad, post_valid, N);
      end
      for (int i = 0; i < got_q.size(); i++) begin
         checks++;
         if ({got_q[i], last_q[i]} !== {ACC_WIDTH'(exp_acc[i]), (i == N - 1)}) begin
            errors++;
            $display("FAIL bp_word word=%0d got %h last=%b expected %h last=%b", i, got_q[i], last_q[i],
                     ACC_WIDTH'(exp_acc[i]), (i == N - 1));
         end
      end
   endtask

   task automatic test_reset_mid_flush();
      run_block(MODE_ONE);
      run_flush(1'b0, 30);
      @(negedge s_clk);
      i_out_ready = 1'b0;
      #2 s_rst_n = 1'b0;
      #1;
      checks++;
      if ({o_psum_grant, o_psum_rd, o_tile_release, o_out_valid, o_out_data, o_out_last, o_busy, o_overrun} !== '0) begin
         errors++;
         $display("FAIL async_reset vld=%b data=%h last=%b busy=%b expected all 0", o_out_valid, o_out_data, o_out_last, o_busy);
      end
      @(negedge s_clk);
      s_rst_n = 1'b1;
      run_block(MODE_IDX);
      run_flush(1'b0, N);
      checks++;
      if (got_q.size() != N) begin errors++; $display("FAIL fresh_count got %0d expected %0d", got_q.size(), N); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== ACC_WIDTH'(TILE_NUM * i)) begin
            errors++;
            $display("FAIL fresh_word word=%0d got %0d expected %0d", i, got_q[i], TILE_NUM * i);
         end
      end
   endtask

   initial begin
      test_reset();
      test_grant_sequence();
      test_overrun();
      test_single_block();
      test_saturation();
      test_backpressure();
      test_reset_mid_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
